spi_rx_shift_register: RTL and testbench
========================================

Name: spi_rx_shift_register

Overview:
- Receive-side neighbour of tx_shift_register in the SPI master core.
- Samples MISO one bit per sample strobe from the SPI clock generator, for char_len bits, honouring lsb ordering. Uses the same go_busy frame semantics as the transmit path.
- Presents a right-aligned received word to the register interface with a valid/ack handshake and a sticky overrun flag.

Parameters:
- DATA_W, 128, width of the receive data register; maximum frame length.
- LEN_W, 7, width of char_len; a char_len of 0 means DATA_W bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- go_busy  input  1  frame enable; held high for the whole frame by the controller.
- char_len  input  LEN_W  frame length in bits; 0 means DATA_W.
- lsb  input  1  1 = LSB-first, 0 = MSB-first.
- sample_en  input  1  single-cycle strobe marking the MISO sampling edge.
- miso  input  1  serial input, already synchronised.
- rx_ack  input  1  consumer acknowledge; clears rx_valid and overrun.
- rx_data  output  DATA_W  last completed word, right-aligned.
- rx_valid  output  1  rx_data holds an unacknowledged word.
- rx_complete  output  1  one-cycle pulse when a frame's last bit is sampled.
- overrun  output  1  sticky: a frame completed while rx_valid was still 1.
- busy  output  1  high in state SHIFT.

Behaviour:
- Reset (async, rst=1): state IDLE; rx_data=0, rx_valid=0, rx_complete=0, overrun=0, busy=0; shift register and bit counter cleared.
- State IDLE:
  - go_busy=1 → SHIFT.
  - On entry to SHIFT: latch char_len (0 → DATA_W) into the length register and lsb into the order register; bit counter=0; shift register=0.
  - Inputs are not re-read during the frame.
- State SHIFT:
  - Each cycle with sample_en=1 captures miso.
  - MSB-first: the shift register shifts left, with miso entering bit 0.
  - LSB-first: miso is written to bit index = bit counter.
  - Bit counter increments on every capture.
  - Capture of bit number len-1 happens in cycle N. In cycle N+1:
    - rx_data = assembled word, with bits ≥ len zero;
    - rx_complete=1 for exactly one cycle;
    - rx_valid=1;
    - state → DONE.
  - Zero cycles of latency are added beyond the registered output.
  - go_busy=0 with no sample_en in the same cycle → abort to IDLE. rx_data, rx_valid and overrun are unchanged, and there is no rx_complete.
  - go_busy=0 and sample_en=1 in the same cycle → abort wins; the bit is discarded.
- State DONE:
  - busy=0; further sample_en is ignored.
  - go_busy=0 → IDLE.
  - A new frame requires go_busy to go low, then high again.
- Handshake:
  - rx_ack=1 clears rx_valid and overrun next cycle.
  - rx_ack while rx_valid=0 has no effect.
- Overrun: set when a frame completes while rx_valid=1 and rx_ack is not asserted in that cycle. rx_data is still overwritten with the new word.
- Simultaneous rx_ack and completion: the completion wins. rx_valid stays 1 and overrun is not set.
- Reset mid-frame: immediate return to the reset values.

Optional Feature:
- Macro: SPI_RX_SIGN_EXT_EN.
- Defined: on completion, bits len..DATA_W-1 of rx_data are filled with bit len-1 of the assembled word (the MSB-first first bit, or the LSB-first last bit).
- Undefined: those bits are zero.
- The feature has no effect when len=DATA_W.

Test Plan:
- char_len=8, lsb=0, miso 1,0,1,0,1,0,0,1 on 8 strobes spaced 2 cycles → rx_data=0xA9, one rx_complete pulse, rx_valid=1, busy falls with completion.
- char_len=8, lsb=1, same miso sequence → rx_data=0x95; rx_ack → rx_valid=0 next cycle.
- Two 8-bit frames, no rx_ack between them, second frame 0x3C → overrun=1, rx_data=0x3C; then rx_ack → overrun=0, rx_valid=0.
- char_len=0, 128 strobes with alternating bits starting at 1, lsb=0 → rx_data = 128'hAAAA…AAAA; separately, char_len=1 with miso=1 → rx_data=1.
- go_busy dropped after 4 of 8 bits → no rx_complete, rx_data and rx_valid unchanged, IDLE. Separately, rst asserted mid-frame → all outputs 0 asynchronously.
- With SPI_RX_SIGN_EXT_EN: char_len=8, lsb=0, rx 0xA9 → rx_data = {120{1'b1}},0xA9. Without the macro → 0xA9 zero-extended.

Source files
------------

// File: rtl/spi_rx_shift_register_if.sv
// Register-side bundle of the SPI receive shift register: frame control,
// serial input, and the received-word handshake.
interface spi_rx_shift_register_if #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 7
);
  logic              go_busy;
  logic [LEN_W-1:0]  char_len;
  logic              lsb;
  logic              sample_en;
  logic              miso;
  logic              rx_ack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_complete;
  logic              overrun;
  logic              busy;

  // Controller / register file side.
  modport master (
    output go_busy,
    output char_len,
    output lsb,
    output sample_en,
    output miso,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  rx_complete,
    input  overrun,
    input  busy
  );

  // Receive shift register side.
  modport slave (
    input  go_busy,
    input  char_len,
    input  lsb,
    input  sample_en,
    input  miso,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output rx_complete,
    output overrun,
    output busy
  );
endinterface

// File: rtl/spi_rx_shift_register.sv
// SPI master receive shift register: samples MISO on each sample strobe and
// presents a right-aligned word. Define SPI_RX_SIGN_EXT_EN to sign-extend short frames.
module spi_rx_shift_register #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_rx_shift_register_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_reg,       state_next;
  logic [CNT_W-1:0]  len_reg,         len_next;
  logic              order_reg,       order_next;
  logic [CNT_W-1:0]  bit_cnt_reg,     bit_cnt_next;
  logic [DATA_W-1:0] shift_reg,       shift_next;
  logic [DATA_W-1:0] rx_data_reg,     rx_data_next;
  logic              rx_valid_reg,    rx_valid_next;
  logic              rx_complete_reg, rx_complete_next;
  logic              overrun_reg,     overrun_next;

  logic [DATA_W-1:0] msb_word;
  logic [DATA_W-1:0] lsb_word;
  logic [DATA_W-1:0] captured_word;
  logic [DATA_W-1:0] len_mask;
  logic [DATA_W-1:0] final_word;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_bit;

  // MSB-first: shift left with the new bit entering at bit 0.
  assign msb_word = {shift_reg[DATA_W-2:0], bus.miso};

  // LSB-first: the new bit lands at the position named by the bit counter;
  // len_mask keeps only the bits below the latched frame length.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bits
      assign lsb_word[gi] = (bit_cnt_reg == CNT_W'(gi)) ? bus.miso : shift_reg[gi];
      assign len_mask[gi] = (CNT_W'(gi) < len_reg);
    end
  endgenerate

  assign captured_word = order_reg ? lsb_word : msb_word;
  assign cnt_inc       = bit_cnt_reg + CNT_W'(1);
  assign last_bit      = (cnt_inc == len_reg);

`ifdef SPI_RX_SIGN_EXT_EN
  logic [IDX_W-1:0] last_idx;
  logic             sign_bit;

  // Bit len-1 is the first bit MSB-first and the last bit LSB-first.
  assign last_idx   = IDX_W'(len_reg - CNT_W'(1));
  assign sign_bit   = captured_word[last_idx];
  assign final_word = (captured_word & len_mask) | (~len_mask & {DATA_W{sign_bit}});
`else
  assign final_word = captured_word & len_mask;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      len_reg         <= '0;
      order_reg       <= 1'b0;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      rx_complete_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      len_reg         <= len_next;
      order_reg       <= order_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      rx_complete_reg <= rx_complete_next;
      overrun_reg     <= overrun_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    len_next         = len_reg;
    order_next       = order_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    rx_data_next     = rx_data_reg;
    rx_valid_next    = rx_valid_reg;
    rx_complete_next = 1'b0;
    overrun_next     = overrun_reg;

    if (bus.rx_ack && rx_valid_reg) begin
      rx_valid_next = 1'b0;
      overrun_next  = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        if (bus.go_busy) begin
          state_next   = SHIFT;
          len_next     = (bus.char_len == '0) ? CNT_W'(DATA_W) : CNT_W'(bus.char_len);
          order_next   = bus.lsb;
          bit_cnt_next = '0;
          shift_next   = '0;
        end
      end

      SHIFT: begin
        // Dropping go_busy aborts even if a strobe arrives in the same cycle.
        if (!bus.go_busy) begin
          state_next = IDLE;
        end else if (bus.sample_en) begin
          shift_next   = captured_word;
          bit_cnt_next = cnt_inc;
          if (last_bit) begin
            state_next       = DONE;
            rx_data_next     = final_word;
            rx_complete_next = 1'b1;
            rx_valid_next    = 1'b1;
            // A same-cycle ack consumes the old word, so no overrun is flagged.
            overrun_next     = bus.rx_ack ? 1'b0 : (overrun_reg | rx_valid_reg);
          end
        end
      end

      DONE: begin
        if (!bus.go_busy) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.rx_data     = rx_data_reg;
  assign bus.rx_valid    = rx_valid_reg;
  assign bus.rx_complete = rx_complete_reg;
  assign bus.overrun     = overrun_reg;
  assign bus.busy        = (state_reg == SHIFT);

endmodule

// File: tb/tb_spi_rx_shift_register.sv
// Randomised bench for spi_rx_shift_register against a frame-level model of
// the received word, handshake and overrun rules.
module tb_spi_rx_shift_register;

  localparam int DATA_W = 128;
  localparam int LEN_W  = 7;

`ifdef SPI_RX_SIGN_EXT_EN
  localparam logic [DATA_W-1:0] FILL8 = {{(DATA_W-8){1'b1}}, 8'h00};
  localparam logic [DATA_W-1:0] FILL1 = {{(DATA_W-1){1'b1}}, 1'b0};
`else
  localparam logic [DATA_W-1:0] FILL8 = '0;
  localparam logic [DATA_W-1:0] FILL1 = '0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_rx_shift_register_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  spi_rx_shift_register #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks   = 0;
  int n_pass     = 0;
  int n_complete = 0;
  bit chk_en     = 1'b0;

  // Frame-level model: expected outputs plus the bits gathered so far.
  logic [DATA_W-1:0] exp_data;
  bit exp_valid, exp_complete, exp_overrun, exp_busy;
  bit m_frame, m_done, m_lsb;
  int m_len;
  bit m_bits[$];

  function automatic void check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endfunction

  function automatic void check_bit(string name, logic act, logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, required %b", name, act, req);
  endfunction

  function automatic void check_int(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endfunction

  // Place the i-th received bit by arithmetic on its position in the frame.
  function automatic logic [DATA_W-1:0] assemble();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < m_len; i++) begin
      if (m_lsb) w[i] = m_bits[i];
      else       w[m_len-1-i] = m_bits[i];
    end
`ifdef SPI_RX_SIGN_EXT_EN
    for (int i = m_len; i < DATA_W; i++) w[i] = w[m_len-1];
`endif
    return w;
  endfunction

  function automatic void model_reset();
    exp_data = '0; exp_valid = 0; exp_complete = 0; exp_overrun = 0; exp_busy = 0;
    m_frame = 0; m_done = 0; m_lsb = 0; m_len = 0;
    m_bits.delete();
  endfunction

  function automatic void model_update(bit gb, bit se, bit mi, bit ack);
    bit completing;
    completing   = 0;
    exp_complete = 0;
    if (m_frame) begin
      if (!gb) m_frame = 0;
      else if (se) begin
        m_bits.push_back(mi);
        if (m_bits.size() == m_len) completing = 1;
      end
    end else if (m_done) begin
      if (!gb) m_done = 0;
    end else if (gb) begin
      m_frame = 1;
      m_len   = (bus.char_len == '0) ? DATA_W : int'(bus.char_len);
      m_lsb   = bus.lsb;
      m_bits.delete();
    end
    if (completing) begin
      exp_data     = assemble();
      exp_complete = 1;
      if (ack) exp_overrun = 0;
      else if (exp_valid) exp_overrun = 1;
      exp_valid = 1;
      m_frame   = 0;
      m_done    = 1;
    end else if (ack && exp_valid) begin
      exp_valid   = 0;
      exp_overrun = 0;
    end
    exp_busy = m_frame;
  endfunction

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("rx_data", bus.rx_data, exp_data);
      check_bit("rx_valid", bus.rx_valid, exp_valid);
      check_bit("rx_complete", bus.rx_complete, exp_complete);
      check_bit("overrun", bus.overrun, exp_overrun);
      check_bit("busy", bus.busy, exp_busy);
      if (bus.rx_complete) n_complete++;
    end
  end

  task automatic step(input bit gb, input bit se, input bit mi, input bit ack);
    bus.go_busy   = gb;
    bus.sample_en = se;
    bus.miso      = mi;
    bus.rx_ack    = ack;
    @(posedge clk);
    #1;
    model_update(gb, se, mi, ack);
  endtask

  // bits[i] is the i-th bit on the wire; abort_after < 0 runs the full frame.
  task automatic run_frame(input int len_field, input bit l, input logic [DATA_W-1:0] bits,
                           input int abort_after, input int gap, input bit rnd);
    int n;
    int g;
    n = (len_field == 0) ? DATA_W : len_field;
    bus.char_len = LEN_W'(len_field);
    bus.lsb      = l;
    step(1, 0, 0, 0);
    bus.char_len = LEN_W'($urandom);
    bus.lsb      = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) begin
        step(0, 1'($urandom), 1'($urandom), 0);
        return;
      end
      step(1, 1, bits[i], rnd && ($urandom_range(0, 3) == 0));
      g = rnd ? int'($urandom_range(0, gap)) : gap;
      for (int k = 0; k < g; k++) step(1, 0, 1'($urandom), rnd && ($urandom_range(0, 5) == 0));
    end
    step(1, 1, 1'($urandom), 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    int c0;
    int len_field;
    int n;
    int abort_at;
    logic [DATA_W-1:0] held;

    bus.go_busy = 0; bus.sample_en = 0; bus.miso = 0; bus.rx_ack = 0;
    bus.char_len = '0; bus.lsb = 0;
    model_reset();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", bus.rx_data, '0);
    check_bit("reset_rx_valid", bus.rx_valid, 1'b0);
    check_bit("reset_rx_complete", bus.rx_complete, 1'b0);
    check_bit("reset_overrun", bus.overrun, 1'b0);
    check_bit("reset_busy", bus.busy, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    step(0, 0, 0, 0);

    // MSB-first 1,0,1,0,1,0,0,1 with strobes two cycles apart.
    c0 = n_complete;
    run_frame(8, 0, 128'h95, -1, 1, 0);
    check("msb8_data", bus.rx_data, FILL8 | 128'hA9);
    check_bit("msb8_valid", bus.rx_valid, 1'b1);
    check_int("msb8_pulses", n_complete - c0, 1);
    step(0, 0, 0, 1);
    check_bit("msb8_ack_valid", bus.rx_valid, 1'b0);

    // Same wire sequence LSB-first.
    run_frame(8, 1, 128'h95, -1, 1, 0);
    check("lsb8_data", bus.rx_data, FILL8 | 128'h95);
    step(0, 0, 0, 1);
    check_bit("lsb8_ack_valid", bus.rx_valid, 1'b0);

    // Two frames without an ack: second one overruns.
    run_frame(8, 0, 128'h5A, -1, 1, 0);
    run_frame(8, 0, 128'h3C, -1, 1, 0);
    check_bit("ovr_set", bus.overrun, 1'b1);
    check("ovr_data", bus.rx_data, 128'h3C);
    step(0, 0, 0, 1);
    check_bit("ovr_cleared", bus.overrun, 1'b0);
    check_bit("ovr_valid_cleared", bus.rx_valid, 1'b0);

    // Full-width frame, back-to-back strobes, alternating bits starting at 1.
    run_frame(0, 0, {64{2'b01}}, -1, 0, 0);
    check("full_data", bus.rx_data, {64{2'b10}});
    step(0, 0, 0, 1);
    run_frame(1, 0, 128'h1, -1, 1, 0);
    check("len1_data", bus.rx_data, FILL1 | 128'h1);

    // Abort after four of eight bits.
    held = bus.rx_data;
    c0 = n_complete;
    run_frame(8, 0, 128'hFF, 4, 1, 0);
    check("abort_data", bus.rx_data, FILL1 | 128'h1);
    check_bit("abort_valid", bus.rx_valid, 1'b1);
    check_int("abort_pulses", n_complete - c0, 0);
    check_bit("abort_busy", bus.busy, 1'b0);
    check("abort_held", bus.rx_data, held);

    // Asynchronous reset in the middle of a frame, away from any clock edge.
    bus.char_len = LEN_W'(8);
    bus.lsb = 0;
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rx_data", bus.rx_data, '0);
    check_bit("arst_rx_valid", bus.rx_valid, 1'b0);
    check_bit("arst_overrun", bus.overrun, 1'b0);
    check_bit("arst_busy", bus.busy, 1'b0);
    bus.go_busy = 0; bus.sample_en = 0; bus.rx_ack = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0);

    // Randomised frames: length, order, spacing, acks, aborts.
    for (int f = 0; f < 40; f++) begin
      len_field = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 127));
      n = (len_field == 0) ? DATA_W : len_field;
      abort_at = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_frame(len_field, 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                abort_at, 2, 1);
      repeat ($urandom_range(0, 2)) step(0, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    step(0, 0, 0, 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
